// File: rtl/vfpu_issue_seq_if.sv
// Port bundle between the VPU dispatch stage, the operand source, the scalar FPU
// and the writeback consumer for one vfpu_issue_seq lane.
interface vfpu_issue_seq_if #(
  parameter int VLMAX = 32,
  parameter int IDX_W = $clog2(VLMAX),
  parameter int OP_W  = 5
);
  // Valid/ready: a beat transfers on a rising edge where valid & ready are both 1.
  // Once raised, valid and its payload stay stable until that transfer happens.
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [OP_W-1:0]   cmd_op_i;
  logic [IDX_W:0]    cmd_vl_i;
  logic              cmd_use_scalar_i;
  logic [31:0]       cmd_scalar_i;

  logic [IDX_W-1:0]  src_idx_o;
  logic [31:0]       src_op1_i;
  logic [31:0]       src_op2_i;
  logic [31:0]       src_op3_i;

  logic [OP_W-1:0]   fpu_op_o;
  logic [31:0]       fpu_operand1_o;
  logic [31:0]       fpu_operand2_o;
  logic [31:0]       fpu_operand3_o;
  logic              fpu_wait_i;
  logic [31:0]       fpu_result_i;

  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [IDX_W-1:0]  wb_idx_o;
  logic [31:0]       wb_data_o;

  logic              busy_o;
  logic              done_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_vl_i, cmd_use_scalar_i, cmd_scalar_i,
    output cmd_ready_o,
    output src_idx_o,
    input  src_op1_i, src_op2_i, src_op3_i,
    output fpu_op_o, fpu_operand1_o, fpu_operand2_o, fpu_operand3_o,
    input  fpu_wait_i, fpu_result_i,
    output wb_valid_o, wb_idx_o, wb_data_o,
    input  wb_ready_i,
    output busy_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_vl_i, cmd_use_scalar_i, cmd_scalar_i,
    input  cmd_ready_o,
    input  src_idx_o,
    output src_op1_i, src_op2_i, src_op3_i,
    input  fpu_op_o, fpu_operand1_o, fpu_operand2_o, fpu_operand3_o,
    output fpu_wait_i, fpu_result_i,
    input  wb_valid_o, wb_idx_o, wb_data_o,
    output wb_ready_i,
    input  busy_o, done_o
  );
endinterface

// File: rtl/vfpu_issue_seq.sv
// Vector FP command sequencer: issues one command element by element to the
// scalar FPU and returns each result through a single-entry writeback register.
package vfpu_pkg;
  typedef enum logic [4:0] {
    _FMVXW  = 5'd0,
    _FMVWX  = 5'd1,
    _FADDS  = 5'd2,
    _FSUBS  = 5'd3,
    _FMULS  = 5'd4,
    _FMADD  = 5'd5,
    _FMSUB  = 5'd6,
    _FNMADD = 5'd7,
    _FNMSUB = 5'd8,
    _FSGNJS = 5'd9,
    _FMINS  = 5'd10,
    _FMAXS  = 5'd11,
    _FEQS   = 5'd12,
    _FLTS   = 5'd13,
    _FLES   = 5'd14,
    _FCVTWS = 5'd15,
    _FCVTSW = 5'd16,
    _FCLASS = 5'd17
  } OPERATOR_t;
endpackage

module vfpu_issue_seq
  import vfpu_pkg::*;
#(
  parameter int        VLMAX   = 32,
  parameter int        IDX_W   = $clog2(VLMAX),
  parameter OPERATOR_t IDLE_OP = _FMVXW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vfpu_issue_seq_if.master bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [IDX_W:0] VL_CAP  = (IDX_W+1)'(VLMAX);
  localparam logic [IDX_W:0] IDX_ONE = (IDX_W+1)'(1);

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [IDX_W:0]   vl_q, vl_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic             use_scalar_q, use_scalar_d;
  logic [31:0]      scalar_q, scalar_d;
  logic             inflight_q, inflight_d;
  logic             wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             done_q, done_d;

  logic [IDX_W:0]   vl_clamped;
  logic             may_issue;
  logic             active;
  logic             complete;
  logic [4:0]       fpu_op;
  logic [31:0]      opnd1, opnd2, opnd3;

  assign vl_clamped = (bus.cmd_vl_i > VL_CAP) ? VL_CAP : bus.cmd_vl_i;
  // A new element may only start if its result has somewhere to land on completion.
  assign may_issue  = !wb_valid_q || bus.wb_ready_i;
  assign active     = (state_q == S_RUN) && (inflight_q || may_issue);
  assign complete   = active && !bus.fpu_wait_i;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    vl_d         = vl_q;
    idx_d        = idx_q;
    use_scalar_d = use_scalar_q;
    scalar_d     = scalar_q;
    inflight_d   = 1'b0;
    wb_valid_d   = wb_valid_q;
    wb_idx_d     = wb_idx_q;
    wb_data_d    = wb_data_q;
    done_d       = 1'b0;
    fpu_op       = IDLE_OP;
    opnd1        = 32'd0;
    opnd2        = 32'd0;
    opnd3        = 32'd0;

    if (wb_valid_q && bus.wb_ready_i) begin
      wb_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          op_d         = bus.cmd_op_i;
          vl_d         = vl_clamped;
          use_scalar_d = bus.cmd_use_scalar_i;
          scalar_d     = bus.cmd_scalar_i;
          idx_d        = '0;
          state_d      = (vl_clamped == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (active) begin
          fpu_op     = op_q;
          opnd1      = bus.src_op1_i;
          opnd2      = use_scalar_q ? scalar_q : bus.src_op2_i;
          opnd3      = bus.src_op3_i;
          inflight_d = bus.fpu_wait_i;
          if (complete) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = idx_q[IDX_W-1:0];
            wb_data_d  = bus.fpu_result_i;
            idx_d      = idx_q + IDX_ONE;
            if (idx_d == vl_q) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!wb_valid_q || bus.wb_ready_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_q         <= IDLE_OP;
      vl_q         <= '0;
      idx_q        <= '0;
      use_scalar_q <= 1'b0;
      scalar_q     <= 32'd0;
      inflight_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_idx_q     <= '0;
      wb_data_q    <= 32'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      vl_q         <= vl_d;
      idx_q        <= idx_d;
      use_scalar_q <= use_scalar_d;
      scalar_q     <= scalar_d;
      inflight_q   <= inflight_d;
      wb_valid_q   <= wb_valid_d;
      wb_idx_q     <= wb_idx_d;
      wb_data_q    <= wb_data_d;
      done_q       <= done_d;
    end
  end

  assign bus.cmd_ready_o    = (state_q == S_IDLE);
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.done_o         = done_q;
  assign bus.src_idx_o      = idx_q[IDX_W-1:0];
  assign bus.fpu_op_o       = fpu_op;
  assign bus.fpu_operand1_o = opnd1;
  assign bus.fpu_operand2_o = opnd2;
  assign bus.fpu_operand3_o = opnd3;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_idx_o       = wb_idx_q;
  assign bus.wb_data_o      = wb_data_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_vfpu_issue_seq.sv
// Directed bench for vfpu_issue_seq with a small two-state FPU stub and an
// operand source that can fold the element index into operand1.
module tb_vfpu_issue_seq;
  import vfpu_pkg::*;

  localparam int VLMAX = 32;
  localparam int IDX_W = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dbg_state;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  logic        fpu_hold = 1'b0;
  logic [31:0] src_base1;
  logic        src_inc;
  logic [31:0] src_v2;
  logic [31:0] src_v3;

  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int          obs_cyc_q[$];

  vfpu_issue_seq_if #(.VLMAX(VLMAX), .IDX_W(IDX_W)) bus();

  vfpu_issue_seq #(.VLMAX(VLMAX), .IDX_W(IDX_W), .IDLE_OP(_FMVXW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic is_two_cycle(input logic [4:0] op);
    return op inside {_FADDS, _FSUBS, _FMADD, _FMSUB, _FNMADD, _FNMSUB};
  endfunction

  // FPU stub: two-cycle ops wait for one cycle each time they are issued.
  always @(posedge clk) fpu_hold <= bus.fpu_wait_i;
  always_comb begin
    bus.fpu_wait_i   = is_two_cycle(bus.fpu_op_o) && !fpu_hold;
    bus.fpu_result_i = 32'hDEAD_BEEF;
    if (bus.fpu_op_o == _FMULS) begin
      if (bus.fpu_operand2_o == 32'h3F80_0000)
        bus.fpu_result_i = bus.fpu_operand1_o;
      else if (bus.fpu_operand1_o == 32'h3FC0_0000 && bus.fpu_operand2_o == 32'h4000_0000)
        bus.fpu_result_i = 32'h4040_0000;
    end else if (bus.fpu_op_o == _FADDS) begin
      if (bus.fpu_operand1_o == 32'h3F80_0000 && bus.fpu_operand2_o == 32'h3F80_0000)
        bus.fpu_result_i = 32'h4000_0000;
    end
  end

  always_comb begin
    bus.src_op1_i = src_base1 + (src_inc ? {27'd0, bus.src_idx_o} : 32'd0);
    bus.src_op2_i = src_v2;
    bus.src_op3_i = src_v3;
  end

  always @(negedge clk) begin
    if (!rst && bus.wb_valid_o && bus.wb_ready_i) begin
      obs_q.push_back({bus.wb_idx_o, bus.wb_data_o});
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [4:0] op, input logic [5:0] vl, input logic us,
                          input logic [31:0] sc, output int acc_cyc);
    bus.cmd_valid_i      = 1'b1;
    bus.cmd_op_i         = op;
    bus.cmd_vl_i         = vl;
    bus.cmd_use_scalar_i = us;
    bus.cmd_scalar_i     = sc;
    @(negedge clk);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.wb_valid_o} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: ready/busy/done/wb_valid=%b required 1000",
               {bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.wb_valid_o});
    end
    vec_cnt++;
    if ({bus.wb_idx_o, bus.wb_data_o, bus.src_idx_o} !== 42'd0) begin
      err_cnt++;
      $display("FAIL reset_wb: wb_idx=%0d wb_data=%h src_idx=%0d required all 0",
               bus.wb_idx_o, bus.wb_data_o, bus.src_idx_o);
    end
    vec_cnt++;
    if (bus.fpu_op_o !== 5'(_FMVXW) ||
        {bus.fpu_operand1_o, bus.fpu_operand2_o, bus.fpu_operand3_o} !== 96'd0) begin
      err_cnt++;
      $display("FAIL reset_fpu: op=%0d opnds=%h %h %h required op=%0d opnds 0",
               bus.fpu_op_o, bus.fpu_operand1_o, bus.fpu_operand2_o, bus.fpu_operand3_o, _FMVXW);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fmuls_stream();
    int acc, dc, base;
    src_base1 = 32'h3FC0_0000; src_inc = 1'b0; src_v2 = 32'h4000_0000; src_v3 = 32'd0;
    bus.wb_ready_i = 1'b1;
    base = obs_q.size();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(i), 32'h4040_0000});
    send_cmd(_FMULS, 6'd4, 1'b0, 32'd0, acc);
    wait_done(20, dc);
    vec_cnt++;
    if (obs_q.size() - base !== 4) begin
      err_cnt++;
      $display("FAIL fmuls_count: beats=%0d required 4", obs_q.size() - base);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (base + i >= obs_q.size()) begin
        err_cnt++;
        $display("FAIL fmuls_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== acc + 2 + i) begin
        err_cnt++;
        $display("FAIL fmuls_beat%0d: got %h @%0d required %h @%0d", i,
                 obs_q[base+i], obs_cyc_q[base+i] - acc, exp_q[i], 2 + i);
      end
    end
    vec_cnt++;
    if (dc !== acc + 6) begin
      err_cnt++;
      $display("FAIL fmuls_done: done at +%0d required +6", dc - acc);
    end
  endtask

  task automatic test_fadds_hold();
    int acc, dc, base, waits;
    logic        prev_wait;
    logic [73:0] prev_snap;
    logic [73:0] snap;
    src_base1 = 32'h3F80_0000; src_inc = 1'b0; src_v2 = 32'h3F80_0000; src_v3 = 32'h7F00_0000;
    base = obs_q.size();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(i), 32'h4000_0000});
    send_cmd(_FADDS, 6'd3, 1'b0, 32'd0, acc);
    prev_wait = 1'b0; prev_snap = '0; waits = 0; dc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      snap = {bus.fpu_op_o, bus.src_idx_o, bus.fpu_operand1_o, bus.fpu_operand2_o};
      if (prev_wait) begin
        vec_cnt++;
        if (snap !== prev_snap || bus.fpu_operand3_o !== 32'h7F00_0000) begin
          err_cnt++;
          $display("FAIL fadds_hold: got %h op3=%h required %h op3=7f000000",
                   snap, bus.fpu_operand3_o, prev_snap);
        end
      end
      if (bus.fpu_wait_i === 1'b1) begin
        waits++;
        vec_cnt++;
        if (bus.fpu_op_o !== 5'(_FADDS)) begin
          err_cnt++;
          $display("FAIL fadds_wait_op: op=%0d required %0d", bus.fpu_op_o, _FADDS);
        end
      end
      prev_wait = bus.fpu_wait_i;
      prev_snap = snap;
      if (bus.done_o === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (waits !== 3) begin
      err_cnt++;
      $display("FAIL fadds_waits: wait cycles=%0d required 3", waits);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (base + i >= obs_q.size()) begin
        err_cnt++;
        $display("FAIL fadds_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== acc + 3 + 2 * i) begin
        err_cnt++;
        $display("FAIL fadds_beat%0d: got %h @%0d required %h @%0d", i,
                 obs_q[base+i], obs_cyc_q[base+i] - acc, exp_q[i], 3 + 2 * i);
      end
    end
    vec_cnt++;
    if (dc !== acc + 8) begin
      err_cnt++;
      $display("FAIL fadds_done: done at +%0d required +8", dc - acc);
    end
  endtask

  task automatic test_wb_stall();
    int acc, dc, base;
    int exp_cyc[3];
    src_base1 = 32'h4000_0000; src_inc = 1'b1; src_v2 = 32'h3F80_0000; src_v3 = 32'd0;
    base = obs_q.size();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(i), 32'h4000_0000 + 32'(i)});
    send_cmd(_FMULS, 6'd3, 1'b0, 32'd0, acc);
    exp_cyc[0] = acc + 2; exp_cyc[1] = acc + 8; exp_cyc[2] = acc + 9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_idx_o !== 5'd1 || bus.wb_data_o !== 32'h4000_0001) begin
        err_cnt++;
        $display("FAIL stall_hold%0d: valid=%b idx=%0d data=%h required 1 1 40000001",
                 i, bus.wb_valid_o, bus.wb_idx_o, bus.wb_data_o);
      end
      vec_cnt++;
      if (bus.fpu_op_o !== 5'(_FMVXW)) begin
        err_cnt++;
        $display("FAIL stall_idle_op%0d: op=%0d required %0d", i, bus.fpu_op_o, _FMVXW);
      end
      @(posedge clk); #1;
    end
    bus.wb_ready_i = 1'b1;
    wait_done(20, dc);
    vec_cnt++;
    if (obs_q.size() - base !== 3) begin
      err_cnt++;
      $display("FAIL stall_count: beats=%0d required 3", obs_q.size() - base);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (base + i >= obs_q.size()) begin
        err_cnt++;
        $display("FAIL stall_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== exp_cyc[i]) begin
        err_cnt++;
        $display("FAIL stall_beat%0d: got %h @%0d required %h @%0d", i,
                 obs_q[base+i], obs_cyc_q[base+i] - acc, exp_q[i], exp_cyc[i] - acc);
      end
    end
    vec_cnt++;
    if (dc !== acc + 10) begin
      err_cnt++;
      $display("FAIL stall_done: done at +%0d required +10", dc - acc);
    end
  endtask

  task automatic test_vl_bounds();
    int acc, dc, base, nbeats;
    base = obs_q.size();
    send_cmd(_FMULS, 6'd0, 1'b0, 32'd0, acc);
    @(negedge clk);
    vec_cnt++;
    if ({bus.cmd_ready_o, bus.busy_o, bus.done_o} !== 3'b010) begin
      err_cnt++;
      $display("FAIL vl0_drain: ready/busy/done=%b required 010",
               {bus.cmd_ready_o, bus.busy_o, bus.done_o});
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.cmd_ready_o, bus.busy_o, bus.done_o} !== 3'b101) begin
      err_cnt++;
      $display("FAIL vl0_done: ready/busy/done=%b required 101",
               {bus.cmd_ready_o, bus.busy_o, bus.done_o});
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++;
    if (bus.done_o !== 1'b0 || obs_q.size() !== base) begin
      err_cnt++;
      $display("FAIL vl0_quiet: done=%b beats=%0d required 0 0", bus.done_o, obs_q.size() - base);
    end
    @(posedge clk); #1;

    src_base1 = 32'h4100_0000; src_inc = 1'b1; src_v2 = 32'h5555_5555; src_v3 = 32'd0;
    base = obs_q.size();
    exp_q.delete();
    for (int i = 0; i < VLMAX; i++) exp_q.push_back({5'(i), 32'h4100_0000 + 32'(i)});
    send_cmd(_FMULS, 6'd40, 1'b1, 32'h3F80_0000, acc);
    wait_done(100, dc);
    nbeats = obs_q.size() - base;
    vec_cnt++;
    if (nbeats !== 32) begin
      err_cnt++;
      $display("FAIL vl40_count: beats=%0d required 32", nbeats);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (base + i >= obs_q.size()) begin
        err_cnt++;
        $display("FAIL vl40_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[base+i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL vl40_beat%0d: got %h required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
    vec_cnt++;
    if (dc !== acc + 34) begin
      err_cnt++;
      $display("FAIL vl40_done: done at +%0d required +34", dc - acc);
    end
  endtask

  task automatic test_scalar();
    int acc, dc, base, issues;
    src_base1 = 32'h4000_0000; src_inc = 1'b1; src_v2 = 32'h1234_5678; src_v3 = 32'd0;
    base = obs_q.size();
    exp_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back({5'(i), 32'h4000_0000 + 32'(i)});
    send_cmd(_FMULS, 6'd2, 1'b1, 32'h3F80_0000, acc);
    issues = 0; dc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fpu_op_o === 5'(_FMULS)) begin
        issues++;
        vec_cnt++;
        if (bus.fpu_operand2_o !== 32'h3F80_0000) begin
          err_cnt++;
          $display("FAIL scalar_opnd2: got %h required 3f800000", bus.fpu_operand2_o);
        end
      end
      if (bus.done_o === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (issues !== 2 || dc !== acc + 4) begin
      err_cnt++;
      $display("FAIL scalar_issues: issues=%0d done=+%0d required 2 +4", issues, dc - acc);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (base + i >= obs_q.size()) begin
        err_cnt++;
        $display("FAIL scalar_beat%0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[base+i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL scalar_beat%0d: got %h required %h", i, obs_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int acc, dc, base;
    logic saw_done;
    src_base1 = 32'h3F80_0000; src_inc = 1'b0; src_v2 = 32'h3F80_0000; src_v3 = 32'd0;
    base = obs_q.size();
    send_cmd(_FADDS, 6'd3, 1'b0, 32'd0, acc);
    @(negedge clk);
    vec_cnt++;
    if (bus.fpu_wait_i !== 1'b1 || bus.fpu_op_o !== 5'(_FADDS)) begin
      err_cnt++;
      $display("FAIL rst_setup: wait=%b op=%0d required 1 %0d", bus.fpu_wait_i, bus.fpu_op_o, _FADDS);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.cmd_ready_o, bus.busy_o, bus.wb_valid_o, bus.done_o} !== 4'b1000 ||
        bus.fpu_op_o !== 5'(_FMVXW)) begin
      err_cnt++;
      $display("FAIL rst_mid: ready/busy/wb_valid/done=%b op=%0d required 1000 op=%0d",
               {bus.cmd_ready_o, bus.busy_o, bus.wb_valid_o, bus.done_o}, bus.fpu_op_o, _FMVXW);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.wb_valid_o === 1'b1) saw_done = 1'b1;
    end
    vec_cnt++;
    if (saw_done !== 1'b0 || obs_q.size() !== base) begin
      err_cnt++;
      $display("FAIL rst_abort: stray done/wb=%b beats=%0d required 0 0", saw_done, obs_q.size() - base);
    end
    @(posedge clk); #1;

    src_base1 = 32'h4000_0000; src_inc = 1'b1; src_v2 = 32'h3F80_0000;
    send_cmd(_FMULS, 6'd1, 1'b0, 32'd0, acc);
    wait_done(20, dc);
    vec_cnt++;
    if (obs_q.size() !== base + 1) begin
      err_cnt++;
      $display("FAIL rst_new_count: beats=%0d required 1", obs_q.size() - base);
    end else if (obs_q[base] !== {5'd0, 32'h4000_0000} || obs_cyc_q[base] !== acc + 2) begin
      err_cnt++;
      $display("FAIL rst_new_beat: got %h @+%0d required 0040000000 @+2",
               obs_q[base], obs_cyc_q[base] - acc);
    end
    vec_cnt++;
    if (dc !== acc + 3) begin
      err_cnt++;
      $display("FAIL rst_new_done: done at +%0d required +3", dc - acc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst                  = 1'b1;
    bus.cmd_valid_i      = 1'b0;
    bus.cmd_op_i         = 5'(_FMVXW);
    bus.cmd_vl_i         = '0;
    bus.cmd_use_scalar_i = 1'b0;
    bus.cmd_scalar_i     = 32'd0;
    bus.wb_ready_i       = 1'b1;
    src_base1            = 32'd0;
    src_inc              = 1'b0;
    src_v2               = 32'd0;
    src_v3               = 32'd0;

    test_reset();
    test_fmuls_stream();
    test_fadds_hold();
    test_wb_stall();
    test_vl_bounds();
    test_scalar();
    test_mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vfpu_issue_seq.md
Name: vfpu_issue_seq

Overview:
- Initiator side of the scalar FPU port: accepts one vector floating-point command and issues it to the FPU element by element.
- Drives op and operands to the FPU and honours its stall (wait) output.
- Captures each result and returns it through a valid/ready writeback port.
- Sits between the VPU decode/dispatch stage and the FPU, one instance per lane.

Parameters:
- VLMAX, 32, maximum elements per command.
- IDX_W, $clog2(VLMAX), element index width.
- IDLE_OP, _FMVXW, single-cycle OPERATOR_t value driven on fpu_op_o when no element is in flight; FPU result is ignored in that case.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  OPERATOR_t  FPU operation
- cmd_vl_i  in  IDX_W+1  element count; values above VLMAX are clamped to VLMAX
- cmd_use_scalar_i  in  1  vector-scalar form: operand2 = cmd_scalar_i
- cmd_scalar_i  in  32  scalar operand
- src_idx_o  out  IDX_W  element index to the operand source (combinational read)
- src_op1_i / src_op2_i / src_op3_i  in  32 each  element operands for src_idx_o, same cycle
- fpu_op_o  out  OPERATOR_t  to FPU op_i
- fpu_operand1_o / fpu_operand2_o / fpu_operand3_o  out  32 each  to FPU operands
- fpu_wait_i  in  1  FPU stall; result valid in the cycle this is 0
- fpu_result_i  in  32  FPU result
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  writeback ready
- wb_idx_o  out  IDX_W  element index of wb_data_o
- wb_data_o  out  32  result
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle pulse when the command is fully written back

Behaviour:
- Reset values: cmd_ready_o=1, busy_o=0, done_o=0, wb_valid_o=0, wb_idx_o=0, wb_data_o=0, src_idx_o=0, fpu_op_o=IDLE_OP, fpu operands=0. All internal state clears.
- Command registers: op, clamped vl, use_scalar and scalar are latched on acceptance.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: cmd_ready_o=1. On accept with vl>0, go to RUN with idx=0. On accept with vl=0, go to DRAIN (done_o pulses the next cycle, no writebacks).
- Issue rule (RUN, no element in flight): may_issue = !wb_valid_o || wb_ready_i.
  - If may_issue: drive fpu_op_o = latched op, operand1 = src_op1_i, operand2 = scalar or src_op2_i, operand3 = src_op3_i, with src_idx_o = idx. The element is now in flight.
  - Otherwise: fpu_op_o = IDLE_OP (FPU stays in its one-cycle state).
- In flight: op and src_idx_o are held constant while fpu_wait_i=1.
  - Completion is the first cycle with fpu_wait_i=0. In that cycle fpu_result_i is registered into wb_data_o, wb_idx_o=idx, and wb_valid_o=1 from the next cycle. idx increments.
  - Completion never stalls, because may_issue guaranteed a free or draining buffer.
- Throughput with wb_ready_i=1:
  - Single-cycle ops: one element per cycle.
  - Two-cycle ops (_FADDS, _FSUBS, _FMADD, _FMSUB, _FNMADD, _FNMSUB): one element per 2 cycles.
  - Back-to-back issue of the same op is legal; the FPU re-enters wait each issue.
- Writeback: a single output register. wb_valid_o clears on wb_valid_o&wb_ready_i unless a completion loads it in the same cycle. Data and index are stable while valid and not ready.
- Last element: completion of element vl-1 moves RUN to DRAIN.
- DRAIN: when wb_valid_o=0, or wb_valid_o&wb_ready_i, pulse done_o for one cycle and return to IDLE. cmd_ready_o=0 outside IDLE.
- Latency: accept to first wb_valid_o is 2 cycles (1-cycle op) or 3 cycles (2-cycle op).
- Reset mid-operation: everything returns to reset values next cycle. fpu_op_o=IDLE_OP forces the FPU back to its one-cycle state within one cycle. No done_o is produced for the aborted command.
- idx does not wrap: width IDX_W+1 internally, compared against vl.

Test Plan:
- _FMULS, vl=4, all src_op1=0x3FC00000, src_op2=0x40000000, wb_ready_i=1 -> wb beats idx 0,1,2,3 on consecutive cycles, data 0x40400000, done_o one cycle after the idx 3 handshake.
- _FADDS, vl=3, op1=0x3F800000, op2=0x3F800000 -> fpu_op_o and operands held across each wait cycle; wb_valid_o beats every 2 cycles; data 0x40000000; idx 0..2.
- _FMULS, vl=3, wb_ready_i low for 5 cycles while idx 1 is valid -> wb_data_o/wb_idx_o stable; fpu_op_o=IDLE_OP during the stall; no element lost or duplicated; idx 2 follows the release.
- vl=0 accept -> cmd_ready_o low 1 cycle, done_o pulses, wb_valid_o never asserts. vl=40 -> exactly 32 writebacks.
- cmd_use_scalar_i=1, cmd_scalar_i=0x3F800000, _FMULS, vl=2 -> fpu_operand2_o=0x3F800000 for both elements regardless of src_op2_i.
- rst_i asserted during an _FADDS wait cycle -> next cycle cmd_ready_o=1, busy_o=0, wb_valid_o=0, fpu_op_o=IDLE_OP; a new _FMULS vl=1 then completes normally.
